// File: rtl/sti_pkg.sv
// Shared types and helpers for the STI parallel-to-serial transmitter.
package sti_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        FINISH
    } state_t;

    localparam logic [1:0] LEN_HALF = 2'b00;
    localparam logic [1:0] LEN_FULL = 2'b01;
    localparam logic [1:0] LEN_1P5  = 2'b10;
    localparam logic [1:0] LEN_DBL  = 2'b11;

    function automatic int unsigned frame_bits(input logic [1:0] len, input int unsigned dw);
        case (len)
            LEN_HALF: return dw / 2;
            LEN_FULL: return dw;
            LEN_1P5:  return (3 * dw) / 2;
            default:  return 2 * dw;
        endcase
    endfunction

endpackage

// File: rtl/sti_fifo.sv
// Synchronous FIFO, DEPTH x W; head entry is visible on rdata with no read latency.
module sti_fifo #(
    parameter int unsigned W     = 21,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign rdata   = mem_q[rptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/sti_pser_fifo.sv
// Buffered parallel-to-serial transmitter with per-word framing and end-of-stream handling.
// Optional trailing even-parity bit per frame when STI_PARITY_EN is defined.
module sti_pser_fifo #(
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic [1:0]    in_len,
    input  logic          in_fill,
    input  logic          in_msb,
    input  logic          in_low,
    input  logic          in_end,
    output logic          so_valid,
    output logic          so_data,
    output logic          so_last,
    output logic          done
);

    import sti_pkg::*;

    localparam int unsigned CW = $clog2(2*DW+1);
    localparam int unsigned EW = DW + 5;
    localparam int unsigned FW = 2 * DW;

    state_t        state_q, state_d;
    logic [FW-1:0] shreg_q, shreg_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          msb_q, msb_d;
    logic          end_seen_q;
    logic          full, empty, push, pop;
    logic [EW-1:0] wdata, rdata;
    logic          tx_bit;

    logic [DW-1:0] e_data;
    logic [1:0]    e_len;
    logic          e_fill, e_msb, e_low;
    logic [CW-1:0] n_bits;
    logic [FW-1:0] frame_c, load_c;

`ifdef STI_PARITY_EN
    logic par_q, par_d;
`endif

    assign wdata    = {in_data, in_len, in_fill, in_msb, in_low};
    assign in_ready = !full && !end_seen_q && (state_q != FINISH);
    assign push     = in_valid && in_ready;

    sti_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .full  (full),
        .empty (empty)
    );

    assign {e_data, e_len, e_fill, e_msb, e_low} = rdata;

    // Frame built from the FIFO head; MSB-first frames are left-aligned so one shift direction per order suffices.
    always_comb begin
        n_bits  = CW'(frame_bits(e_len, DW));
        frame_c = '0;
        case (e_len)
            LEN_HALF: frame_c[DW/2-1:0] = e_low ? e_data[DW-1:DW/2] : e_data[DW/2-1:0];
            LEN_FULL: frame_c[DW-1:0]   = e_data;
            default:  frame_c = e_fill ? ({{DW{1'b0}}, e_data} << (n_bits - CW'(DW)))
                                       : {{DW{1'b0}}, e_data};
        endcase
        load_c = e_msb ? (frame_c << (CW'(FW) - n_bits)) : frame_c;
    end

`ifdef STI_PARITY_EN
    assign tx_bit = (cnt_q == '0) ? par_q : (msb_q ? shreg_q[FW-1] : shreg_q[0]);
`else
    assign tx_bit = msb_q ? shreg_q[FW-1] : shreg_q[0];
`endif

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        msb_d   = msb_q;
        pop     = 1'b0;
`ifdef STI_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (!empty)          state_d = LOAD;
                else if (end_seen_q) state_d = FINISH;
            end
            LOAD: begin
                pop     = 1'b1;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (cnt_q == '0) begin
                    if (!empty) pop = 1'b1;
                    else        state_d = IDLE;
                end else begin
                    shreg_d = msb_q ? (shreg_q << 1) : (shreg_q >> 1);
                    cnt_d   = cnt_q - CW'(1);
                end
            end
            default: state_d = FINISH;
        endcase

        if (pop) begin
            shreg_d = load_c;
            msb_d   = e_msb;
`ifdef STI_PARITY_EN
            cnt_d   = n_bits;
            par_d   = ^frame_c;
`else
            cnt_d   = n_bits - CW'(1);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            cnt_q      <= '0;
            msb_q      <= 1'b0;
            end_seen_q <= 1'b0;
`ifdef STI_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            msb_q      <= msb_d;
            end_seen_q <= end_seen_q | in_end;
`ifdef STI_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    assign so_valid = (state_q == SHIFT);
    assign so_last  = so_valid && (cnt_q == '0);
    assign so_data  = so_valid && tx_bit;
    assign done     = (state_q == FINISH);

endmodule
